// File: rtl/ikaopm_pkg.sv
// Shared definitions for the OPM host write scheduler.
//   state_t     : scheduler FSM states
//   SLOT_W      : width of the broadcast slot index
//   FRAME_SLOTS : number of slots in one timing-generator frame
//   BUSY_W      : width of the host busy counter
package ikaopm_pkg;

    localparam int SLOT_W      = 5;
    localparam int FRAME_SLOTS = 32;
    localparam int BUSY_W      = 8;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_SLOTS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        BCAST     = 2'd2
    } state_t;

endpackage

// File: rtl/ikaopm_busy_counter.sv
// Host busy-flag down-counter.
//   i_EMUCLK : master clock
//   i_RST    : synchronous active-high reset
//   load     : reload counter with LOAD_VALUE (takes priority over dec)
//   dec      : decrement by one while nonzero
//   hold     : force busy high regardless of the count
//   busy     : count nonzero, or hold asserted
module ikaopm_busy_counter
    import ikaopm_pkg::*;
#(
    parameter int LOAD_VALUE = 64
) (
    input  logic i_EMUCLK,
    input  logic i_RST,
    input  logic load,
    input  logic dec,
    input  logic hold,
    output logic busy
);

    logic [BUSY_W-1:0] cnt;

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= BUSY_W'(LOAD_VALUE);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0) | hold;

endmodule

// File: rtl/ikaopm_write_scheduler.sv
// Host-side register write scheduler for the OPM core. Captures host
// address/data writes, raises busy, waits for a frame boundary and then
// broadcasts the committed address/data pair for one full 32-slot frame.
//
//   i_EMUCLK       : master clock
//   i_RST          : synchronous active-high reset
//   i_phi1_NCEN_n  : phi1 clock enable, active low; sequencing ticks
//   i_CYCLE_31     : frame-boundary marker from the timing generator
//   i_WR, i_A0     : host write strobe; A0=0 address, A0=1 data
//   i_DIN          : host write data
//   o_BUSY         : host busy flag
//   o_REG_WR       : register write broadcast active
//   o_REG_ADDR     : committed register address
//   o_REG_DATA     : committed register data
//   o_SLOT         : broadcast slot index (0 outside broadcast)
//   o_OVERRUN      : sticky, data write seen while busy
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | nothing pending, register write path quiet
// WAIT_SYNC | data committed, waiting for a phi1 tick with CYCLE_31
// BCAST     | driving o_REG_WR for slots 0..31, one per phi1 tick
module ikaopm_write_scheduler
    import ikaopm_pkg::*;
#(
    parameter int BUSY_CYCLES          = 64,
    parameter bit RESTART_ON_OVERWRITE = 1'b1
) (
    input  logic              i_EMUCLK,
    input  logic              i_RST,
    input  logic              i_phi1_NCEN_n,
    input  logic              i_CYCLE_31,
    input  logic              i_WR,
    input  logic              i_A0,
    input  logic [7:0]        i_DIN,
    output logic              o_BUSY,
    output logic              o_REG_WR,
    output logic [7:0]        o_REG_ADDR,
    output logic [7:0]        o_REG_DATA,
    output logic [SLOT_W-1:0] o_SLOT,
    output logic              o_OVERRUN
);

    state_t            state, state_nxt;
    logic [SLOT_W-1:0] slot, slot_nxt;
    logic [7:0]        pend_addr;

    logic phi1_tick;
    logic addr_wr;
    logic data_wr;
    logic accept;

    assign phi1_tick = ~i_phi1_NCEN_n;
    assign addr_wr   = i_WR & ~i_A0;
    assign data_wr   = i_WR &  i_A0;
    // A data write while busy only restarts the sequence when enabled.
    assign accept    = data_wr & (~o_BUSY | RESTART_ON_OVERWRITE);

    // Busy stays up through the whole broadcast even if the count runs out.
    ikaopm_busy_counter #(
        .LOAD_VALUE (BUSY_CYCLES)
    ) u_busy (
        .i_EMUCLK (i_EMUCLK),
        .i_RST    (i_RST),
        .load     (accept),
        .dec      (phi1_tick),
        .hold     (state == BCAST),
        .busy     (o_BUSY)
    );

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state <= IDLE;
            slot  <= '0;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
        end
    end

    // An accepted data write overrides any phi1-driven transition on the same edge.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        if (accept) begin
            state_nxt = WAIT_SYNC;
            slot_nxt  = '0;
        end else if (phi1_tick) begin
            case (state)
                WAIT_SYNC: begin
                    if (i_CYCLE_31) begin
                        state_nxt = BCAST;
                        slot_nxt  = '0;
                    end
                end
                BCAST: begin
                    if (slot == LAST_SLOT) begin
                        state_nxt = IDLE;
                        slot_nxt  = '0;
                    end else begin
                        slot_nxt  = slot + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            pend_addr  <= '0;
            o_REG_ADDR <= '0;
            o_REG_DATA <= '0;
            o_OVERRUN  <= 1'b0;
        end else begin
            if (addr_wr) begin
                pend_addr <= i_DIN;
            end
            if (accept) begin
                o_REG_ADDR <= pend_addr;
                o_REG_DATA <= i_DIN;
            end
            if (data_wr && o_BUSY) begin
                o_OVERRUN <= 1'b1;
            end
        end
    end

    assign o_REG_WR = (state == BCAST);
    assign o_SLOT   = (state == BCAST) ? slot : '0;

endmodule

// File: tb/tb_ikaopm_write_scheduler.sv
module tb_ikaopm_write_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       ncen_n;
    logic       c31;
    logic       wr;
    logic       a0;
    logic [7:0] din;

    logic       busy, reg_wr, ovr;
    logic [7:0] reg_addr, reg_data;
    logic [4:0] slot;

    logic       nr_busy, nr_reg_wr, nr_ovr;
    logic [7:0] nr_reg_addr, nr_reg_data;
    logic [4:0] nr_slot;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ikaopm_write_scheduler #(
        .BUSY_CYCLES          (64),
        .RESTART_ON_OVERWRITE (1'b1)
    ) dut (
        .i_EMUCLK      (clk),
        .i_RST         (rst),
        .i_phi1_NCEN_n (ncen_n),
        .i_CYCLE_31    (c31),
        .i_WR          (wr),
        .i_A0          (a0),
        .i_DIN         (din),
        .o_BUSY        (busy),
        .o_REG_WR      (reg_wr),
        .o_REG_ADDR    (reg_addr),
        .o_REG_DATA    (reg_data),
        .o_SLOT        (slot),
        .o_OVERRUN     (ovr)
    );

    ikaopm_write_scheduler #(
        .BUSY_CYCLES          (64),
        .RESTART_ON_OVERWRITE (1'b0)
    ) dut_nr (
        .i_EMUCLK      (clk),
        .i_RST         (rst),
        .i_phi1_NCEN_n (ncen_n),
        .i_CYCLE_31    (c31),
        .i_WR          (wr),
        .i_A0          (a0),
        .i_DIN         (din),
        .o_BUSY        (nr_busy),
        .o_REG_WR      (nr_reg_wr),
        .o_REG_ADDR    (nr_reg_addr),
        .o_REG_DATA    (nr_reg_data),
        .o_SLOT        (nr_slot),
        .o_OVERRUN     (nr_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One i_EMUCLK cycle; inputs applied before the edge, outputs sampled 1ns after.
    task automatic step(input logic nc, input logic c, input logic w, input logic a,
                        input logic [7:0] d);
        ncen_n = nc; c31 = c; wr = w; a0 = a; din = d;
        @(posedge clk);
        #1;
        ncen_n = 1'b1; c31 = 1'b0; wr = 1'b0; a0 = 1'b0; din = 8'h00;
    endtask

    task automatic tick(input logic c);
        step(1'b0, c, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wr_addr(input logic [7:0] d);
        step(1'b1, 1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic wr_data(input logic [7:0] d);
        step(1'b1, 1'b0, 1'b1, 1'b1, d);
    endtask

    initial begin
        rst = 1'b1; ncen_n = 1'b1; c31 = 1'b0; wr = 1'b0; a0 = 1'b0; din = 8'h00;

        // Reset and idle
        idle(); idle(); idle();
        chk("rst_busy", busy, 0);
        chk("rst_regwr", reg_wr, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_data", reg_data, 0);
        chk("rst_slot", slot, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_nr_busy", nr_busy, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            chk("idle_busy", busy, 0);
            chk("idle_regwr", reg_wr, 0);
        end

        // Address 0x20, data 0xC7, boundary after 10 ticks
        wr_addr(8'h20);
        chk("a20_busy", busy, 0);
        chk("a20_addr_uncommitted", reg_addr, 0);
        wr_data(8'hC7);
        chk("c7_busy_rise", busy, 1);
        chk("c7_addr", reg_addr, 8'h20);
        chk("c7_data", reg_data, 8'hC7);
        chk("c7_regwr", reg_wr, 0);
        for (int i = 0; i < 9; i++) begin
            tick(1'b0);
            chk("wait_regwr", reg_wr, 0);
        end
        tick(1'b1);
        chk("bc_regwr_s0", reg_wr, 1);
        chk("bc_slot_s0", slot, 0);
        idle();
        chk("bc_noadv_slot", slot, 0);
        chk("bc_noadv_regwr", reg_wr, 1);
        for (int s = 1; s < 32; s++) begin
            tick(1'b0);
            chk("bc_regwr", reg_wr, 1);
            chk("bc_slot", slot, s);
            chk("bc_addr", reg_addr, 8'h20);
            chk("bc_data", reg_data, 8'hC7);
        end
        tick(1'b0);
        chk("bc_end_regwr", reg_wr, 0);
        chk("bc_end_slot", slot, 0);
        chk("bc_end_busy", busy, 1);
        // 42 ticks so far since the write; busy falls at tick 64
        for (int i = 0; i < 21; i++) tick(1'b0);
        chk("busy_tick63", busy, 1);
        tick(1'b0);
        chk("busy_tick64", busy, 0);
        chk("no_ovr", ovr, 0);

        // Address write during broadcast does not disturb committed address
        wr_data(8'h33);
        chk("d33_addr", reg_addr, 8'h20);
        tick(1'b1);
        chk("d33_regwr", reg_wr, 1);
        for (int i = 0; i < 3; i++) tick(1'b0);
        chk("d33_slot3", slot, 3);
        wr_addr(8'h08);
        chk("a08_addr_hold", reg_addr, 8'h20);
        chk("a08_slot", slot, 3);
        for (int s = 4; s < 32; s++) begin
            tick(1'b0);
            chk("a08_bc_addr", reg_addr, 8'h20);
            chk("a08_bc_slot", slot, s);
        end
        tick(1'b0);
        chk("d33_end_regwr", reg_wr, 0);
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            tick(1'b0);
        end
        chk("d33_busy_timeout", busy, 0);
        wr_data(8'h55);
        chk("d55_addr", reg_addr, 8'h08);
        chk("d55_data", reg_data, 8'h55);
        chk("d55_ovr", ovr, 0);
        chk("d55_nr_addr", nr_reg_addr, 8'h08);
        chk("d55_nr_ovr", nr_ovr, 0);

        // Data write 0x11 at slot 12
        tick(1'b1);
        for (int i = 0; i < 12; i++) tick(1'b0);
        chk("ow_slot12", slot, 12);
        chk("ow_nr_slot12", nr_slot, 12);
        wr_data(8'h11);
        chk("ow_regwr_drop", reg_wr, 0);
        chk("ow_ovr", ovr, 1);
        chk("ow_busy", busy, 1);
        chk("ow_data", reg_data, 8'h11);
        chk("ow_slot0", slot, 0);
        chk("ow_nr_regwr", nr_reg_wr, 1);
        chk("ow_nr_slot", nr_slot, 12);
        chk("ow_nr_data", nr_reg_data, 8'h55);
        chk("ow_nr_ovr", nr_ovr, 1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            chk("ow_wait_regwr", reg_wr, 0);
            chk("ow_nr_slot_run", nr_slot, 13 + i);
        end
        tick(1'b1);
        chk("rb_regwr", reg_wr, 1);
        chk("rb_slot0", slot, 0);
        chk("rb_data", reg_data, 8'h11);
        chk("rb_addr", reg_addr, 8'h08);
        chk("rb_nr_slot16", nr_slot, 16);
        for (int k = 1; k < 16; k++) begin
            tick(1'b0);
            chk("rb_slot", slot, k);
            chk("rb_nr_slot", nr_slot, 16 + k);
            chk("rb_nr_data", nr_reg_data, 8'h55);
            chk("rb_nr_regwr", nr_reg_wr, 1);
        end
        tick(1'b0);
        chk("rb_nr_end_regwr", nr_reg_wr, 0);
        chk("rb_nr_end_data", nr_reg_data, 8'h55);
        chk("rb_slot16", slot, 16);

        // Reset mid-broadcast, plus write colliding with the sync tick
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("r2_ovr_clear", ovr, 0);
        wr_data(8'h44);
        chk("d44_addr", reg_addr, 8'h00);
        chk("d44_busy", busy, 1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h45);
        chk("coll_regwr", reg_wr, 0);
        chk("coll_data", reg_data, 8'h45);
        tick(1'b1);
        chk("coll_bc_regwr", reg_wr, 1);
        chk("coll_bc_data", reg_data, 8'h45);
        for (int i = 0; i < 5; i++) tick(1'b0);
        chk("r3_slot5", slot, 5);
        rst = 1'b1;
        idle();
        chk("r3_regwr", reg_wr, 0);
        chk("r3_busy", busy, 0);
        chk("r3_slot", slot, 0);
        chk("r3_data", reg_data, 0);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick((i % 8) == 0);
            chk("r3_post_regwr", reg_wr, 0);
            chk("r3_post_busy", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
